menu_ram_arbiter: RTL and testbench

- Two-requester scheduler in front of the single-port SDRAM controller (`sram`) in the MENU core, running in the clk_ram domain.
- Port A is the high-priority line-fetch read port for the video path. Port B is the general read/write port for the fill/test writer and future OSD buffers.
- Issues one transaction at a time and waits for its completion, so the controller is never issued a second command while one is in flight.
- Includes a B-starvation guard and a completion timeout so a hung controller cannot lock either requester.

---
 rtl/menu_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_menu_ram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_ram_arbiter.sv
// Two-port scheduler in front of the MENU single-port SDRAM controller (clk_ram domain).
// Port A (video line fetch) has priority; port B is protected by a starvation guard.
module menu_ram_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64,
  parameter int AW         = 25
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_init,

  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [15:0]   a_dout,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_din,
  input  logic [1:0]    b_wtbt,
  output logic          b_ack,
  output logic [15:0]   b_dout,

  output logic          err,

  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_wtbt,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_nxt;
  logic          owner_b;
  logic          is_write;
  logic          grant_a;

  // A wins unless B is waiting and A has already had STARVE_MAX turns in a row.
  assign grant_a = a_req && (!b_req || (starve_cnt < STARVE_LIM));
  assign tmo_nxt = tmo_cnt + TW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      owner_b    <= 1'b0;
      is_write   <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      err        <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wtbt   <= 2'b11;
    end else begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      err    <= 1'b0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;

      case (state)
        IDLE: begin
          if (!mem_init && (a_req || b_req)) begin
            if (grant_a) begin
              owner_b  <= 1'b0;
              is_write <= 1'b0;
              mem_addr <= a_addr;
              mem_din  <= '0;
              mem_wtbt <= 2'b11;
              mem_rd   <= 1'b1;
              if (!b_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + SW'(1);
              end
            end else begin
              owner_b    <= 1'b1;
              is_write   <= b_we;
              mem_addr   <= b_addr;
              mem_din    <= b_din;
              mem_wtbt   <= b_wtbt;
              mem_rd     <= !b_we;
              mem_we     <= b_we;
              starve_cnt <= '0;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end

        // A completion always beats a timeout landing on the same cycle.
        WAIT: begin
          tmo_cnt <= tmo_nxt;
          if (mem_ready) begin
            if (!is_write) begin
              if (owner_b) b_dout <= mem_dout;
              else         a_dout <= mem_dout;
            end
            a_ack <= !owner_b;
            b_ack <= owner_b;
            state <= DONE;
          end else if (tmo_nxt == TMO_LAST) begin
            a_ack <= !owner_b;
            b_ack <= owner_b;
            err   <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_ram_arbiter.sv
// Self-checking bench for menu_ram_arbiter: vector table, hand-built corner sequences,
// and a randomized run against a transaction-level model with an emulated controller.
module tb_menu_ram_arbiter;

  localparam int AW  = 25;
  localparam int TMO = 64;
  localparam int SMX = 4;
  localparam int NV  = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_init;
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_ack;
  logic [15:0]   a_dout;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [15:0]   b_din;
  logic [1:0]    b_wtbt;
  logic          b_ack;
  logic [15:0]   b_dout;
  logic          err;
  logic          mem_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_wtbt;
  logic [15:0]   mem_dout;
  logic          mem_ready;

  always #5 clk = ~clk;

  menu_ram_arbiter #(.STARVE_MAX(SMX), .TIMEOUT(TMO), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_init(mem_init),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_wtbt(b_wtbt),
    .b_ack(b_ack), .b_dout(b_dout), .err(err),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wtbt(mem_wtbt), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  typedef struct {
    logic          a;
    logic          b;
    logic          bwe;
    logic [AW-1:0] aaddr;
    logic [AW-1:0] baddr;
    logic [15:0]   bdin;
    logic [1:0]    bwtbt;
    int            gap;
    logic [15:0]   rdata;
    logic          expb;
    logic          expwe;
    logic [AW-1:0] expaddr;
    logic [15:0]   expdin;
    logic [1:0]    expwtbt;
    int            expoff;
    logic          experr;
    logic [15:0]   expad;
    logic [15:0]   expbd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] mem_model [logic [AW-1:0]];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_req  = v.a;
    b_req  = v.b;
    b_we   = v.bwe;
    a_addr = v.aaddr;
    b_addr = v.baddr;
    b_din  = v.bdin;
    b_wtbt = v.bwtbt;
  endtask

  task automatic waitStrobe(output int lat);
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      tick();
      if (mem_rd || mem_we) lat = k;
    end
  endtask

  // Called in the strobe cycle; returns cycles from strobe to the first ack.
  task automatic completeTxn(input int gap, input logic [15:0] rdata,
                             output int off, output logic [2:0] acks);
    off  = -1;
    acks = '0;
    for (int k = 0; k < 80 && off < 0; k++) begin
      mem_ready = (gap != 0 && k == gap);
      mem_dout  = mem_ready ? rdata : 16'($urandom);
      tick();
      if (a_ack || b_ack) begin
        off  = k + 1;
        acks = {a_ack, b_ack, err};
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_strobes"}, {30'd0, mem_rd, mem_we}, 32'd0);
    checkOutput({tag, "_acks"}, {29'd0, a_ack, b_ack, err}, 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_din"}, 32'(mem_din), 32'd0);
    checkOutput({tag, "_wtbt"}, 32'(mem_wtbt), 32'd3);
    checkOutput({tag, "_douts"}, {a_dout, b_dout}, 32'd0);
  endtask

  function automatic logic [15:0] memRead(input logic [AW-1:0] addr);
    if (mem_model.exists(addr)) return mem_model[addr];
    return addr[15:0] ^ 16'h5A5A;
  endfunction

  task automatic memWrite(input logic [AW-1:0] addr, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] cur;
    cur = memRead(addr);
    if (be[1]) cur[15:8] = d[15:8];
    if (be[0]) cur[7:0]  = d[7:0];
    mem_model[addr] = cur;
  endtask

  vec_t        vecs [NV];
  vec_t        idle_vec;
  logic [9:0]  pat;
  logic [15:0] ea, eb, rd;
  int          lat, off, n;
  logic [2:0]  acks;

  // Randomized-phase model state.
  logic          ap, bp, bw, own_b, own_we, exp_ack;
  logic [AW-1:0] aa, ba, own_addr;
  logic [15:0]   bd, rdat;
  logic [1:0]    bt;
  int            busy, s_cyc, gap, starve, pend;

  initial begin
    reset_n   = 1'b0;
    mem_init  = 1'b0;
    mem_ready = 1'b0;
    mem_dout  = '0;
    idle_vec  = '{1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 0, '0, 1'b0, 1'b0, '0, '0, 2'b11, 0, 1'b0, '0, '0};
    applyStimulus(idle_vec);

    vecs[0] = '{1'b1, 1'b0, 1'b0, 25'h000100, 25'h0, 16'h0, 2'b00, 3, 16'hBEEF,
                1'b0, 1'b0, 25'h000100, 16'h0, 2'b11, 4, 1'b0, 16'hBEEF, 16'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 25'h0, 25'h1FFFFFF, 16'h1234, 2'b01, 2, 16'hDEAD,
                1'b1, 1'b1, 25'h1FFFFFF, 16'h1234, 2'b01, 3, 1'b0, 16'hBEEF, 16'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 25'h0, 25'h55, 16'h0, 2'b10, 1, 16'hA5A5,
                1'b1, 1'b0, 25'h55, 16'h0, 2'b10, 2, 1'b0, 16'hBEEF, 16'hA5A5};
    // Both requesters held: A four times, then B is forced.
    pat = 10'b1000010000;
    ea  = 16'hBEEF;
    eb  = 16'hA5A5;
    for (int j = 0; j < 10; j++) begin
      rd = 16'h3000 + 16'(j);
      if (pat[j]) eb = rd;
      else        ea = rd;
      vecs[3+j] = '{1'b1, 1'b1, 1'b0, 25'h200 + 25'(j), 25'h77, 16'h0, 2'b11, (j % 3) + 1, rd,
                    pat[j], 1'b0, pat[j] ? 25'h77 : 25'h200 + 25'(j), 16'h0, 2'b11,
                    (j % 3) + 2, 1'b0, ea, eb};
    end
    vecs[13] = '{1'b1, 1'b0, 1'b0, 25'h0ABCDE, 25'h0, 16'h0, 2'b00, 0, 16'h0,
                 1'b0, 1'b0, 25'h0ABCDE, 16'h0, 2'b11, TMO, 1'b1, ea, eb};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 25'h0ABCDF, 25'h0, 16'h0, 2'b00, 1, 16'h4242,
                 1'b0, 1'b0, 25'h0ABCDF, 16'h0, 2'b11, 2, 1'b0, 16'h4242, eb};

    tick();
    tick();
    checkReset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] vector table");
    applyStimulus(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      waitStrobe(lat);
      checkOutput("strobeSeen", {31'd0, lat > 0}, 32'd1);
      if (lat > 0) begin
        checkOutput("strobeKind", {30'd0, mem_rd, mem_we}, vecs[i].expwe ? 32'd1 : 32'd2);
        checkOutput("strobeAddr", 32'(mem_addr), 32'(vecs[i].expaddr));
        checkOutput("strobeWtbt", 32'(mem_wtbt), 32'(vecs[i].expwtbt));
        if (vecs[i].expwe) checkOutput("strobeDin", 32'(mem_din), 32'(vecs[i].expdin));
        completeTxn(vecs[i].gap, vecs[i].rdata, off, acks);
        checkOutput("ackAddrHeld", 32'(mem_addr), 32'(vecs[i].expaddr));
        checkOutput("ackOffset", off, vecs[i].expoff);
        checkOutput("ackBits", 32'(acks), {29'd0, !vecs[i].expb, vecs[i].expb, vecs[i].experr});
        checkOutput("aDout", 32'(a_dout), 32'(vecs[i].expad));
        checkOutput("bDout", 32'(b_dout), 32'(vecs[i].expbd));
      end
      if (i + 1 < NV) applyStimulus(vecs[i+1]);
      else            applyStimulus(idle_vec);
    end

    $display("[TB] mem_init sequence");
    mem_init = 1'b1;
    a_req    = 1'b1;
    a_addr   = 25'h123;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_rd || mem_we) n++;
    end
    checkOutput("initNoStrobe", n, 0);
    mem_init = 1'b0;
    waitStrobe(lat);
    checkOutput("initReleaseLat", {31'd0, lat inside {[1:2]}}, 32'd1);
    checkOutput("initReleaseRd", {30'd0, mem_rd, mem_we}, 32'd2);
    mem_init = 1'b1;
    completeTxn(2, 16'h5151, off, acks);
    checkOutput("initMidOffset", off, 3);
    checkOutput("initMidAck", 32'(acks), 32'd4);
    checkOutput("initMidDout", 32'(a_dout), 32'h5151);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_rd || mem_we) n++;
    end
    checkOutput("initHeldNoStrobe", n, 0);
    mem_init = 1'b0;
    waitStrobe(lat);
    checkOutput("initReissue", {31'd0, lat > 0}, 32'd1);
    completeTxn(1, 16'h6161, off, acks);
    a_req = 1'b0;
    checkOutput("initReissueDout", 32'(a_dout), 32'h6161);

    $display("[TB] reset during WAIT");
    tick();
    a_req  = 1'b1;
    a_addr = 25'h321;
    waitStrobe(lat);
    tick();
    #2 reset_n = 1'b0;
    #1 checkReset("asyncReset");
    tick();
    tick();
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    mem_dout  = 16'hDEAD;
    tick();
    mem_ready = 1'b0;
    checkOutput("postResetStrobe", {30'd0, mem_rd, mem_we}, 32'd2);
    checkOutput("staleReadyIgnored", {29'd0, a_ack, b_ack, err}, 32'd0);
    checkOutput("postResetAddr", 32'(mem_addr), 32'h321);
    completeTxn(2, 16'h7777, off, acks);
    a_req = 1'b0;
    checkOutput("postResetOffset", off, 3);
    checkOutput("postResetDout", 32'(a_dout), 32'h7777);

    $display("[TB] randomized run");
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    ea = '0; eb = '0;
    ap = 1'b0; bp = 1'b0; bw = 1'b0;
    aa = '0; ba = '0; bd = '0; bt = 2'b11;
    own_b = 1'b0; own_we = 1'b0; own_addr = '0; rdat = '0;
    busy = 0; s_cyc = 0; gap = 0; starve = 0; pend = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (mem_rd || mem_we) begin
        if (busy != 0 || !(ap || bp)) begin
          checkOutput("rndSpuriousStrobe", {30'd0, mem_rd, mem_we}, 32'd0);
        end else begin
          own_b = !(ap && (!bp || starve < SMX));
          if (own_b)   starve = 0;
          else if (bp) starve = (starve < SMX) ? starve + 1 : SMX;
          else         starve = 0;
          own_we   = own_b && bw;
          own_addr = own_b ? ba : aa;
          checkOutput("rndStrobeKind", {30'd0, mem_rd, mem_we}, own_we ? 32'd1 : 32'd2);
          checkOutput("rndStrobeAddr", 32'(mem_addr), 32'(own_addr));
          checkOutput("rndStrobeWtbt", 32'(mem_wtbt), own_b ? 32'(bt) : 32'd3);
          if (own_we) checkOutput("rndStrobeDin", 32'(mem_din), 32'(bd));
          busy  = 1;
          s_cyc = cyc;
          gap   = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
          if (own_we) begin
            if (gap != 0) memWrite(own_addr, bd, bt);
          end else begin
            rdat = memRead(own_addr);
          end
        end
      end

      exp_ack = (busy != 0) && (cyc == s_cyc + ((gap == 0) ? TMO : gap + 1));
      if (exp_ack && gap != 0 && !own_we) begin
        if (own_b) eb = rdat;
        else       ea = rdat;
      end
      checkOutput("rndAck", {29'd0, a_ack, b_ack, err},
                  {29'd0, exp_ack && !own_b, exp_ack && own_b, exp_ack && gap == 0});
      if (exp_ack) begin
        checkOutput("rndADout", 32'(a_dout), 32'(ea));
        checkOutput("rndBDout", 32'(b_dout), 32'(eb));
        busy = 0;
        if (own_b) bp = 1'b0;
        else       ap = 1'b0;
      end else if (busy != 0) begin
        checkOutput("rndAddrHeld", 32'(mem_addr), 32'(own_addr));
      end

      mem_ready = (busy != 0) && gap != 0 && (cyc == s_cyc + gap);
      mem_dout  = mem_ready ? rdat : 16'($urandom);

      if (!ap && $urandom_range(0, 2) == 0) begin
        ap = 1'b1;
        aa = 25'($urandom_range(0, 31));
      end
      if (!bp && $urandom_range(0, 2) == 0) begin
        bp = 1'b1;
        ba = 25'($urandom_range(0, 31));
        bw = 1'($urandom_range(0, 1));
        bd = 16'($urandom);
        bt = 2'($urandom_range(1, 3));
      end
      a_req  = ap;
      a_addr = aa;
      b_req  = bp;
      b_addr = ba;
      b_we   = bw;
      b_din  = bd;
      b_wtbt = bt;

      if (busy == 0 && (ap || bp)) begin
        pend++;
        if (pend > 3) begin
          checkOutput("rndGrantWait", pend, 3);
          pend = 0;
        end
      end else begin
        pend = 0;
      end
    end
    mem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
